gelato_ram_arbiter: RTL and testbench

- Shares one GPU RAM port (word address out; 32-bit read data and done strobe back) between NUM_REQ requesters, e.g. instruction fetch and load/store units.
- Round-robin arbitration.
- One outstanding access at a time; per-requester response pulse.
- Sits between the SM front-end/LSU and the RAM model or controller.

---
 rtl/gelato_ram_arb_pkg.sv | 11 +
 rtl/gelato_rr_picker.sv | 26 ++
 rtl/gelato_ram_arbiter.sv | 99 +++++++++
 tb/tb_gelato_ram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_ram_arb_pkg.sv
// gelato_ram_arb_pkg: shared state type and default widths for the RAM arbiter.
package gelato_ram_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  function automatic int wdt_width(input int limit);
    return (limit < 256) ? 8 : $clog2(limit + 1);
  endfunction
endpackage

// File: rtl/gelato_rr_picker.sv
// gelato_rr_picker: combinational round-robin pick, first valid index after last with wrap.
module gelato_rr_picker #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  always_comb begin
    any = 1'b0;
    idx = '0;
    j = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(last) + k) % N);
      if (!any && req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/gelato_ram_arbiter.sv
// gelato_ram_arbiter: round-robin sharing of one RAM read port, one access in flight.
// Optional watchdog in BUSY enabled by GELATO_RAM_ARB_TIMEOUT_EN.
module gelato_ram_arbiter
  import gelato_ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_err,
  output logic                          ram_req,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  input  logic [DATA_WIDTH-1:0]         ram_data,
  input  logic                          ram_done,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IW-1:0] id_q, last_q, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic pick_any, expire;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  gelato_rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (req_valid),
    .last(last_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef GELATO_RAM_ARB_TIMEOUT_EN
  localparam int CW = wdt_width(TIMEOUT_CYCLES);
  logic [CW-1:0] wdt_q;
  logic err_q;
  assign expire = (state_q == ARB_BUSY) && (wdt_q == CW'(TIMEOUT_CYCLES - 1));
  assign resp_err = (state_q == ARB_RESP) && err_q;
  // err_q tracks "no done this cycle" so its last BUSY value explains the exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_q <= '0;
      err_q <= 1'b0;
    end else if (rdy) begin
      wdt_q <= (state_q == ARB_BUSY) ? wdt_q + 1'b1 : '0;
      err_q <= (state_q == ARB_BUSY) ? !ram_done : 1'b0;
    end
  end
`else
  assign expire = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      addr_q <= '0;
      data_q <= '0;
      id_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      if (rdy && state_q == ARB_IDLE && pick_any) begin
        addr_q <= addr_arr[pick_idx];
        id_q <= pick_idx;
        last_q <= pick_idx;
      end
      if (rdy && state_q == ARB_BUSY && (ram_done || expire))
        data_q <= ram_done ? ram_data : '0;
    end
  end

  always_comb begin
    state_d = !rdy ? state_q :
              (state_q == ARB_IDLE) ? (pick_any ? ARB_BUSY : ARB_IDLE) :
              (state_q == ARB_BUSY) ? ((ram_done || expire) ? ARB_RESP : ARB_BUSY) :
              ARB_IDLE;
    req_ready = (state_q == ARB_IDLE && rdy && !rst) ? pick_gnt : '0;
    resp_valid = (state_q == ARB_RESP) ? (NUM_REQ'(1) << id_q) : '0;
    resp_data = (state_q == ARB_RESP) ? data_q : '0;
    ram_req = (state_q == ARB_BUSY);
    ram_addr = (state_q == ARB_BUSY) ? addr_q : '0;
    busy = (state_q != ARB_IDLE);
  end
endmodule

// File: tb/tb_gelato_ram_arbiter.sv
// tb_gelato_ram_arbiter: directed scenarios plus randomized run against a transaction-level model.
module tb_gelato_ram_arbiter;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b0, ram_done = 1'b0;
  logic ram_req, resp_err, busy;
  logic [N-1:0] req_valid = '0, req_ready, resp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [DW-1:0] resp_data, ram_data = '0;
  logic [AW-1:0] ram_addr;
  int total = 0, bad = 0;

  gelato_ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_data(ram_data), .ram_done(ram_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    req_valid = '1;
    ram_done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({req_ready, resp_valid, resp_data, resp_err, ram_req, ram_addr, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b resp=%b data=%h err=%b ram_req=%b addr=%h busy=%b, want all 0",
               req_ready, resp_valid, resp_data, resp_err, ram_req, ram_addr, busy);
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 32'h10;
    ram_done = 1'b1;
    ram_data = 32'hDEADBEEF;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: ready=%b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    total++;
    if (ram_req !== 1'b1 || ram_addr !== 32'h10 || resp_valid !== '0) begin
      bad++; $display("FAIL single_busy: ram_req=%b addr=%h resp=%b want 1/00000010/0000", ram_req, ram_addr, resp_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (resp_valid !== 4'b0100 || resp_data !== 32'hDEADBEEF || resp_err !== 1'b0 || ram_req !== 1'b0) begin
      bad++; $display("FAIL single_resp: resp=%b data=%h err=%b ram_req=%b want 0100/deadbeef/0/0", resp_valid, resp_data, resp_err, ram_req);
    end
    @(negedge clk);
    #1;
    total++;
    if (resp_valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle: resp=%b busy=%b want 0000/0", resp_valid, busy); end
  endtask

  task automatic test_round_robin();
    int k = 0;
    do_reset();
    req_valid = '1;
    ram_done = 1'b1;
    for (int c = 0; c < 20 && k < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req_ready !== '0) begin
        total++;
        if (req_ready !== (N'(1) << (k % N))) begin
          bad++; $display("FAIL rr_order[%0d]: ready=%b want %b", k, req_ready, N'(1) << (k % N));
        end
        k++;
      end
    end
    total++;
    if (k != 5) begin bad++; $display("FAIL rr_count: grants=%0d want 5", k); end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_slow_ram();
    logic [AW-1:0] a = $urandom;
    logic [DW-1:0] d = $urandom;
    @(negedge clk);
    req_valid = 4'b0010;
    req_addr[1*AW +: AW] = a;
    ram_done = 1'b0;
    ram_data = d;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL slow_grant: ready=%b want 0010", req_ready); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid = '0;
      ram_done = (c == 5);
      #1;
      total++;
      if (ram_req !== 1'b1 || ram_addr !== a || resp_valid !== '0) begin
        bad++; $display("FAIL slow_busy[%0d]: ram_req=%b addr=%h resp=%b want 1/%h/0000", c, ram_req, ram_addr, resp_valid, a);
      end
    end
    @(negedge clk);
    ram_done = 1'b0;
    #1;
    total++;
    if (resp_valid !== 4'b0010 || resp_data !== d) begin
      bad++; $display("FAIL slow_resp: resp=%b data=%h want 0010/%h", resp_valid, resp_data, d);
    end
    @(negedge clk);
    #1;
    total++;
    if (resp_valid !== '0) begin bad++; $display("FAIL slow_single: resp=%b want 0000", resp_valid); end
  endtask

  task automatic test_rdy_stall();
    logic [AW-1:0] a = $urandom;
    logic [DW-1:0] d = $urandom;
    @(negedge clk);
    req_valid = 4'b1000;
    req_addr[3*AW +: AW] = a;
    ram_done = 1'b1;
    ram_data = d;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin bad++; $display("FAIL stall_grant: ready=%b want 1000", req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rdy = 1'b0;
      req_valid = 4'b0001;
      #1;
      total++;
      if (ram_req !== 1'b1 || ram_addr !== a || resp_valid !== '0 || req_ready !== '0) begin
        bad++; $display("FAIL stall_frozen[%0d]: ram_req=%b addr=%h resp=%b ready=%b want 1/%h/0000/0000",
                        c, ram_req, ram_addr, resp_valid, req_ready, a);
      end
    end
    @(negedge clk);
    rdy = 1'b1;
    #1;
    total++;
    if (ram_req !== 1'b1 || req_ready !== '0) begin bad++; $display("FAIL stall_resume: ram_req=%b ready=%b want 1/0000", ram_req, req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    total++;
    if (resp_valid !== 4'b1000 || resp_data !== d) begin
      bad++; $display("FAIL stall_resp: resp=%b data=%h want 1000/%h", resp_valid, resp_data, d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 4'b0001;
    req_addr[0 +: AW] = $urandom;
    ram_done = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_grant: ready=%b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    total++;
    if (ram_req !== 1'b1) begin bad++; $display("FAIL midrst_busy: ram_req=%b want 1", ram_req); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (ram_req !== 1'b0 || busy !== 1'b0 || resp_valid !== '0 || ram_addr !== '0) begin
      bad++; $display("FAIL midrst_async: ram_req=%b busy=%b resp=%b addr=%h want all 0", ram_req, busy, resp_valid, ram_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0011;
    ram_done = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_priority: ready=%b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    total++;
    if (resp_valid !== 4'b0001) begin bad++; $display("FAIL midrst_resp: resp=%b want 0001", resp_valid); end
    @(negedge clk);
  endtask

`ifdef GELATO_RAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int s = 0; s < 2; s++) begin
      logic [DW-1:0] d = $urandom | 32'h1;
      @(negedge clk);
      req_valid = 4'b0100;
      ram_done = 1'b0;
      ram_data = d;
      #1;
      for (int c = 1; c <= TO; c++) begin
        @(negedge clk);
        req_valid = '0;
        ram_done = (s == 1 && c == TO);
        #1;
        total++;
        if (ram_req !== 1'b1 || resp_valid !== '0) begin
          bad++; $display("FAIL timeout_busy[%0d.%0d]: ram_req=%b resp=%b want 1/0000", s, c, ram_req, resp_valid);
        end
      end
      @(negedge clk);
      ram_done = 1'b0;
      #1;
      total++;
      if (resp_valid !== 4'b0100 || resp_err !== (s == 0) || resp_data !== ((s == 0) ? '0 : d)) begin
        bad++; $display("FAIL timeout_resp[%0d]: resp=%b err=%b data=%h want 0100/%b/%h",
                        s, resp_valid, resp_err, resp_data, s == 0, (s == 0) ? '0 : d);
      end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_random();
    bit m_have = 0, m_resp = 0, m_err = 0;
    int m_id = 0, m_last = N - 1, m_wait = 0, p;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [N-1:0] e_ready, e_resp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rdy = ($urandom % 8) != 0;
      req_valid = N'($urandom);
      req_addr = {$urandom, $urandom, $urandom, $urandom};
      ram_done = ($urandom % 3) == 0;
      ram_data = $urandom;
      #1;
      p = -1;
      for (int k = 1; k <= N; k++) if (p < 0 && req_valid[(m_last + k) % N]) p = (m_last + k) % N;
      e_ready = (!m_have && !m_resp && rdy && p >= 0) ? (N'(1) << p) : '0;
      e_resp = m_resp ? (N'(1) << m_id) : '0;
      total++;
      if (req_ready !== e_ready || resp_valid !== e_resp || ram_req !== m_have || busy !== (m_have || m_resp) ||
          ram_addr !== (m_have ? m_addr : '0) || resp_data !== (m_resp ? m_data : '0) || resp_err !== (m_resp && m_err)) begin
        bad++;
        $display("FAIL random[%0d]: ready=%b resp=%b data=%h err=%b ram_req=%b addr=%h busy=%b want %b/%b/%h/%b/%b/%h/%b",
                 c, req_ready, resp_valid, resp_data, resp_err, ram_req, ram_addr, busy,
                 e_ready, e_resp, m_resp ? m_data : '0, m_resp && m_err, m_have, m_have ? m_addr : '0, m_have || m_resp);
      end
      if (rdy) begin
        if (m_resp) m_resp = 0;
        else if (m_have) begin
          m_wait++;
          if (ram_done) begin
            m_data = ram_data; m_err = 0; m_have = 0; m_resp = 1;
          end
`ifdef GELATO_RAM_ARB_TIMEOUT_EN
          else if (m_wait == TO) begin
            m_data = '0; m_err = 1; m_have = 0; m_resp = 1;
          end
`endif
        end else if (p >= 0) begin
          m_have = 1; m_id = p; m_last = p; m_wait = 0; m_addr = req_addr[p*AW +: AW];
        end
      end
    end
    @(negedge clk);
    rdy = 1'b1;
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_slow_ram();
    test_rdy_stall();
    test_reset_mid();
`ifdef GELATO_RAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
